// File: rtl/data_ram_bytelane.sv
`default_nettype none
// ============================================================================
// Module      : data_ram_bytelane
// Description : Single-port byte-lane-writable data RAM with registered,
//               read-first reads, alignment/range checking and a full clear.
// Revision    : 1.0 - initial release
// ============================================================================
module data_ram_bytelane #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_req,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [31:0]             addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int NBYTES   = DATA_WIDTH / 8;
    localparam int OFS      = $clog2(NBYTES);
    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int HI_SHIFT = OFS + ADDR_WIDTH;
    localparam logic [31:0]           ALIGN_MASK = 32'((1 << OFS) - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = {ADDR_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    w_legal;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [NBYTES-1:0]       w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_waddr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;

    // Legal means word-aligned and inside the array; upper address bits must be zero.
    assign w_legal = ((addr & ALIGN_MASK) == 32'd0) && ((addr >> HI_SHIFT) == 32'd0);
    assign w_idx   = addr[OFS +: ADDR_WIDTH];

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rd_valid_d  = 1'b0;
        err_d       = 1'b0;
        w_mem_we    = '0;
        w_mem_waddr = clr_cnt_q;
        w_mem_wdata = '0;
        case (state_q)
            CLEAR: begin
                w_mem_we  = '1;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (clr_cnt_q == LAST_WORD) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end else if (wr_en || rd_en) begin
                    if (!w_legal) begin
                        err_d = 1'b1;
                    end else begin
                        rd_valid_d = rd_en;
                        if (wr_en) begin
                            w_mem_we    = wr_be;
                            w_mem_waddr = w_idx;
                            w_mem_wdata = wr_data;
                        end
                    end
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Read register sees the pre-write word, giving read-first behaviour on collisions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_valid_d) begin
            rd_data_q <= mem[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NBYTES; k++) begin
            if (w_mem_we[k]) begin
                mem[w_mem_waddr][8*k +: 8] <= w_mem_wdata[8*k +: 8];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign busy     = (state_q == CLEAR);

endmodule
`default_nettype wire

// File: doc/data_ram_bytelane.md
DATA_RAM_BYTELANE -- requirements
Module: data_ram_bytelane

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width in bits; it SHALL be a multiple of 8 and at least 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning log2 of the word count, so DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL derive the local parameter NBYTES = DATA_WIDTH/8 and OFS = log2(NBYTES); NBYTES SHALL be a power of two.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port clear_req, input, 1 bit: a request to zero the whole array.
REQ-007 The block SHALL have port wr_en, input, 1 bit: a write request.
REQ-008 The block SHALL have port wr_be, input, NBYTES bits: byte-lane write enables, where bit k covers wr_data[8k+7:8k].
REQ-009 The block SHALL have port rd_en, input, 1 bit: a read request.
REQ-010 The block SHALL have port addr, input, 32 bits: the byte address shared by read and write.
REQ-011 The block SHALL have port wr_data, input, DATA_WIDTH bits: the write data.
REQ-012 The block SHALL have port rd_data, output, DATA_WIDTH bits: registered read data.
REQ-013 The block SHALL have port rd_valid, output, 1 bit: a one-cycle pulse qualifying rd_data.
REQ-014 The block SHALL have port busy, output, 1 bit: high while clearing; requests are ignored while it is high.
REQ-015 The block SHALL have port err, output, 1 bit: a one-cycle pulse for a rejected access.

Function
REQ-016 The word index SHALL be addr[OFS+ADDR_WIDTH-1:OFS].
REQ-017 An access SHALL be legal only when addr[OFS-1:0]==0 and addr[31:OFS+ADDR_WIDTH]==0.
REQ-018 An access is a cycle in IDLE with wr_en or rd_en high.
REQ-019 An illegal access SHALL modify no memory, SHALL NOT pulse rd_valid, and SHALL pulse err one cycle later.
REQ-020 A legal write SHALL update, at the clock edge, only the byte lanes whose wr_be bit is 1.
REQ-021 A write with wr_be==0 SHALL be a legal no-op, with no err pulse.
REQ-022 A legal read SHALL load rd_data and pulse rd_valid high on the next edge, giving latency 1.
REQ-023 rd_data SHALL hold its last value when there is no read; the output is never tri-stated.
REQ-024 When a read and a write target the same word in the same cycle, the read SHALL return the old word (read-first), and the write SHALL still occur.
REQ-025 The FSM SHALL have two states: CLEAR and IDLE.
REQ-026 In CLEAR, the block SHALL write zero to word clr_cnt each cycle, increment clr_cnt, and hold busy=1.
REQ-027 When clr_cnt==DEPTH-1 and that word is written, the FSM SHALL move to IDLE with busy=0, with no wrap to 0 re-clear.
REQ-028 In IDLE, clear_req=1 SHALL move the FSM to CLEAR with clr_cnt=0 and busy=1 on the next edge; any wr_en/rd_en in that same cycle SHALL be ignored.
REQ-029 In CLEAR, wr_en, rd_en and clear_req SHALL be ignored, with no err and no rd_valid.
REQ-030 A full clear SHALL take exactly DEPTH cycles of busy=1.
REQ-031 The array SHALL be inferable as synchronous RAM, with no per-word reset loop.

Reset
REQ-032 While reset is high: state=CLEAR, clr_cnt=0, busy=1, rd_data=0, rd_valid=0, err=0.
REQ-033 After reset falls, the block SHALL perform a full clear (REQ-026..030) before accepting any access.
REQ-034 Reset asserted mid-clear or mid-access SHALL abort it immediately and restart per REQ-032; array contents during reset are don't-care.

Verification
REQ-035 Release reset and count busy cycles -> busy is high for exactly 256 cycles after release; a read of any word then returns 0x00000000.
REQ-036 Write 0xDEADBEEF to addr 0x10 with wr_be=4'hF, then write 0x11223344 to addr 0x10 with wr_be=4'b0101, then read -> rd_data=0xDE22BE44 with rd_valid high exactly 1 cycle after rd_en.
REQ-037 Write 0xAAAAAAAA to addr 0x3FC and read addr 0x3FC in the same cycle -> rd_data=old value 0; a following read returns 0xAAAAAAAA.
REQ-038 Access addr 0x0002, then addr 0x0400 -> err pulses once per access, memory is unchanged, rd_valid stays 0.
REQ-039 Assert clear_req with wr_en to addr 0x8 (data 0x5) in IDLE -> write ignored, busy high for 256 cycles, rd_en during busy produces no rd_valid, addr 0x8 reads 0 afterwards.
REQ-040 Assert reset at clr_cnt=100 -> outputs take the REQ-032 values immediately; after release, busy lasts 256 full cycles.
